// File: rtl/lb_bridge_pkg.sv
// lb_bridge_pkg: shared definitions for the krv32-to-local-bus bridge.
// Holds the FSM state encoding and the data pattern returned on a
// timed-out read (only produced when LB_BRIDGE_TIMEOUT_EN is defined).
package lb_bridge_pkg;

  // Bridge FSM states; the encoding is fixed so debug probes can decode it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    ACK  = 2'd3
  } state_t;

  // Read data handed back to the core when a local-bus read never answers.
  localparam logic [31:0] LB_ERR_DATA = 32'hDEAD_BEEF;

endpackage : lb_bridge_pkg

// File: rtl/lb_bridge_if.sv
// lb_bridge_if: bundles the core-side memory port and the local-bus
// write/read channels that pass through lb_bridge.
//   slave  : the bridge's view (takes CPU requests, drives the local bus)
//   master : the surroundings' view (CPU plus peripheral together)
interface lb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);

  // core-side memory port
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // local-bus write channel
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wen;
  logic              wready;

  // local-bus read channel
  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  // timeout indication, coincident with mem_ready
  logic              lb_err;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output waddr, wdata, wstrb, wen,
    input  wready,
    output raddr, ren,
    input  rdata, rvalid,
    output lb_err
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  waddr, wdata, wstrb, wen,
    output wready,
    input  raddr, ren,
    output rdata, rvalid,
    input  lb_err
  );

endinterface : lb_bridge_if

// File: rtl/lb_watchdog.sv
// lb_watchdog: wait-cycle counter for lb_bridge local-bus transfers.
// Only built when LB_BRIDGE_TIMEOUT_EN is defined; without that macro
// this file contributes no module and the bridge waits indefinitely.
// The counter sits at zero while the bridge is not waiting, so every
// transfer starts counting from zero. expired is high in the last
// permitted wait cycle (count == TIMEOUT_CYCLES-1).
`ifdef LB_BRIDGE_TIMEOUT_EN
module lb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  // Count wait cycles while a transfer is outstanding, hold at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (busy) begin
      count_reg <= count_reg + CNT_W'(1);
    end else begin
      count_reg <= '0;
    end
  end

  assign expired = busy && (count_reg == LIMIT);

endmodule : lb_watchdog
`endif

// File: rtl/lb_bridge.sv
// lb_bridge: krv32 native memory port to Corsair local bus.
// Each CPU access that hits the BASE_ADDR window becomes exactly one
// local-bus write (wstrb != 0) or read (wstrb == 0); misses are ignored.
// Every output is a flop; mem_ready is a single-cycle completion pulse.
// Optional feature: define LB_BRIDGE_TIMEOUT_EN to abandon a local-bus
// transfer after TIMEOUT_CYCLES wait cycles, completing it with lb_err=1
// (and LB_ERR_DATA as read data). Without it lb_err is tied low.
module lb_bridge
  import lb_bridge_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              STRB_W         = DATA_W / 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h4000_0000,
  parameter logic [ADDR_W-1:0] ADDR_MASK    = 32'h0000_00FF,
  parameter int              TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  lb_bridge_if.slave  bus
);

  state_t            state_reg;
  state_t            state_next;

  logic              hit;
  logic              is_write;
  logic              handshake;
  logic              expired;
  logic [ADDR_W-1:0] offset;

  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [STRB_W-1:0] wstrb_reg;
  logic [ADDR_W-1:0] raddr_reg;
  logic              wen_reg;
  logic              ren_reg;
  logic              mem_ready_reg;
  logic [DATA_W-1:0] mem_rdata_reg;

  assign hit       = bus.mem_valid && ((bus.mem_addr & ~ADDR_MASK) == BASE_ADDR);
  assign is_write  = (bus.mem_wstrb != '0);
  assign offset    = bus.mem_addr & ADDR_MASK;
  assign handshake = ((state_reg == WR) && bus.wready) ||
                     ((state_reg == RD) && bus.rvalid);

`ifdef LB_BRIDGE_TIMEOUT_EN
  logic busy;
  logic wd_expired;
  logic lb_err_reg;

  assign busy = (state_reg == WR) || (state_reg == RD);

  lb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .expired (wd_expired)
  );

  // A handshake landing in the expiry cycle completes normally.
  assign expired = wd_expired && !handshake;

  // Error flag rides along with the ACK entered through a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_err_reg <= 1'b0;
    end else begin
      lb_err_reg <= expired;
    end
  end

  assign bus.lb_err = lb_err_reg;
`else
  // Keeps the timeout parameter referenced in builds that have no counter.
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign expired    = 1'b0;
  assign bus.lb_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept hits only in IDLE, leave WR/RD on handshake or expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          state_next = is_write ? WR : RD;
        end
      end
      WR: begin
        if (bus.wready || expired) begin
          state_next = ACK;
        end
      end
      RD: begin
        if (bus.rvalid || expired) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_reg       <= 1'b0;
      ren_reg       <= 1'b0;
      mem_ready_reg <= 1'b0;
    end else begin
      wen_reg       <= (state_next == WR);
      ren_reg       <= (state_next == RD);
      mem_ready_reg <= (state_next == ACK);
    end
  end

  // Latch the request fields of an accepted hit; the unused channel keeps its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_reg <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      raddr_reg <= '0;
    end else if ((state_reg == IDLE) && hit) begin
      if (is_write) begin
        waddr_reg <= offset;
        wdata_reg <= bus.mem_wdata;
        wstrb_reg <= bus.mem_wstrb;
      end else begin
        raddr_reg <= offset;
      end
    end
  end

  // Read data: captured on rvalid, error pattern on read timeout, zero for write completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata_reg <= '0;
    end else if ((state_reg == RD) && bus.rvalid) begin
      mem_rdata_reg <= bus.rdata;
    end else if ((state_reg == RD) && expired) begin
      mem_rdata_reg <= DATA_W'(LB_ERR_DATA);
    end else if ((state_reg == WR) && (state_next == ACK)) begin
      mem_rdata_reg <= '0;
    end
  end

  assign bus.waddr     = waddr_reg;
  assign bus.wdata     = wdata_reg;
  assign bus.wstrb     = wstrb_reg;
  assign bus.wen       = wen_reg;
  assign bus.raddr     = raddr_reg;
  assign bus.ren       = ren_reg;
  assign bus.mem_ready = mem_ready_reg;
  assign bus.mem_rdata = mem_rdata_reg;

endmodule : lb_bridge

// File: tb/tb_lb_bridge.sv
// tb_lb_bridge: self-checking bench for lb_bridge.
// A transaction-level model sets, cycle by cycle, what the bridge outputs
// must be; one compare process checks them every cycle. The peripheral
// memory is filled only from what the bridge actually writes, and read
// data is checked against a separate CPU-side scoreboard.
// Timeout cases run only when LB_BRIDGE_TIMEOUT_EN is defined.
module tb_lb_bridge;
  import lb_bridge_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lb_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lb_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .STRB_W         (4),
    .BASE_ADDR      (32'h4000_0000),
    .ADDR_MASK      (32'h0000_00FF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_wen = 1'b0, exp_ren = 1'b0, exp_rdy = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
  logic [3:0]  exp_wstrb = '0;

  // observations used by the literal checks
  int          rdy_cnt = 0, wen_cnt = 0, ren_cnt = 0;
  int          last_rdy_cyc = 0, last_wen_cyc = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0, last_waddr = '0, last_wdata = '0;

  logic [31:0] periph [64];
  logic [31:0] model  [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_idle_exp();
    exp_wen = 1'b0;
    exp_ren = 1'b0;
    exp_rdy = 1'b0;
    exp_err = 1'b0;
  endtask

  // per-cycle compare plus monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en && !rst) begin
        check("wen", bus.wen, exp_wen);
        check("ren", bus.ren, exp_ren);
        check("mem_ready", bus.mem_ready, exp_rdy);
        check("lb_err", bus.lb_err, exp_err);
        check("mem_rdata", bus.mem_rdata, exp_rdata);
        check("wen_and_ren", bus.wen & bus.ren, 32'd0);
        if (exp_wen) begin
          check("waddr", bus.waddr, exp_addr);
          check("wdata", bus.wdata, exp_wdata);
          check("wstrb", bus.wstrb, exp_wstrb);
        end
        if (exp_ren) begin
          check("raddr", bus.raddr, exp_addr);
        end
      end
      if (!rst) begin
        if (bus.wen) begin
          wen_cnt++;
          last_wen_cyc = cyc;
          last_waddr   = bus.waddr;
          last_wdata   = bus.wdata;
        end
        if (bus.ren) ren_cnt++;
        if (bus.mem_ready) begin
          rdy_cnt++;
          last_rdy_cyc = cyc;
          last_rdata   = bus.mem_rdata;
          last_err     = bus.lb_err;
        end
        if (bus.wen && bus.wready) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.wstrb[b]) periph[bus.waddr[7:2]][8*b +: 8] = bus.wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // one CPU access with a local-bus answer after d wait cycles
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                      input int d, output int c0);
    logic        hit;
    logic [31:0] off;
    logic [31:0] resp;
    int          nb;
    bit          tmo;
    hit = ((addr & ~32'h0000_00FF) == 32'h4000_0000);
    off = addr & 32'h0000_00FF;
    @(negedge clk);
    c0            = cyc;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    bus.wready    = 1'b0;
    bus.rvalid    = 1'b0;
    set_idle_exp();
    if (!hit) begin
      repeat (20) begin
        @(negedge clk);
        set_idle_exp();
      end
      bus.mem_valid = 1'b0;
    end else begin
`ifdef LB_BRIDGE_TIMEOUT_EN
      tmo = (d >= TO);
`else
      tmo = 1'b0;
`endif
      nb = tmo ? TO : d + 1;
      for (int i = 1; i <= nb; i++) begin
        @(negedge clk);
        exp_wen   = (ws != 4'd0);
        exp_ren   = (ws == 4'd0);
        exp_rdy   = 1'b0;
        exp_err   = 1'b0;
        exp_addr  = off;
        exp_wdata = wd;
        exp_wstrb = ws;
        resp      = periph[off[7:2]];
        if (!tmo && i == nb) begin
          bus.wready = (ws != 4'd0);
          bus.rvalid = (ws == 4'd0);
          bus.rdata  = resp;
        end else begin
          bus.wready = 1'b0;
          bus.rvalid = 1'b0;
          bus.rdata  = ~resp;
        end
      end
      @(negedge clk);
      bus.wready = 1'b0;
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      exp_wen    = 1'b0;
      exp_ren    = 1'b0;
      exp_rdy    = 1'b1;
      exp_err    = tmo;
      if (ws != 4'd0)  exp_rdata = 32'd0;
      else if (tmo)    exp_rdata = 32'hDEAD_BEEF;
      else             exp_rdata = model[off[7:2]];
      if (ws != 4'd0 && !tmo) begin
        for (int b = 0; b < 4; b++) begin
          if (ws[b]) model[off[7:2]][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
  endtask

  // idle cycles, optionally with stray wready/rvalid
  task automatic idle(input int n, input bit stray);
    repeat (n) begin
      @(negedge clk);
      bus.mem_valid = 1'b0;
      bus.wready    = stray;
      bus.rvalid    = stray;
      set_idle_exp();
    end
  endtask

  // runaway guard
  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int c0, w0, r0, k0, d;
    logic [31:0] off, wd;
    logic [3:0]  ws;

    for (int i = 0; i < 64; i++) begin
      periph[i] = 32'd0;
      model[i]  = 32'd0;
    end
    periph[4] = 32'h0000_0001;
    model[4]  = 32'h0000_0001;

    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    bus.wready    = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_wen", bus.wen, 32'd0);
    check("rst_ren", bus.ren, 32'd0);
    check("rst_ready", bus.mem_ready, 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    check("rst_waddr", bus.waddr, 32'd0);
    check("rst_lb_err", bus.lb_err, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_idle_exp();
    exp_rdata = 32'd0;
    chk_en    = 1'b1;
    idle(2, 1'b0);

    // minimum-latency write
    w0 = wen_cnt; k0 = rdy_cnt;
    xfer(32'h4000_0004, 32'h0000_0080, 4'hF, 0, c0);
    #2;
    check("t1_wen_cycles", wen_cnt - w0, 32'd1);
    check("t1_wen_cyc", last_wen_cyc - c0, 32'd1);
    check("t1_waddr", last_waddr, 32'h0000_0004);
    check("t1_wdata", last_wdata, 32'h0000_0080);
    check("t1_ready_cyc", last_rdy_cyc - c0, 32'd2);
    check("t1_ready_cnt", rdy_cnt - k0, 32'd1);
    check("t1_lb_err", last_err, 32'd0);

    // read with three wait cycles
    r0 = ren_cnt;
    xfer(32'h4000_0010, 32'h0, 4'h0, 3, c0);
    #2;
    check("t2_ren_cycles", ren_cnt - r0, 32'd4);
    check("t2_ready_cyc", last_rdy_cyc - c0, 32'd5);
    check("t2_rdata", last_rdata, 32'h0000_0001);

    // handshakes outside WR/RD are ignored
    idle(3, 1'b1);
    idle(1, 1'b0);

    // window misses
    w0 = wen_cnt; r0 = ren_cnt; k0 = rdy_cnt;
    xfer(32'h5000_0000, 32'h1234_5678, 4'hF, 0, c0);
    xfer(32'h4000_0100, 32'h0, 4'h0, 0, c0);
    check("t3_miss_wen", wen_cnt - w0, 32'd0);
    check("t3_miss_ren", ren_cnt - r0, 32'd0);
    check("t3_miss_ready", rdy_cnt - k0, 32'd0);

    // reset in the middle of a read
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h4000_0020;
    bus.mem_wstrb = 4'h0;
    bus.wready    = 1'b0;
    bus.rvalid    = 1'b0;
    set_idle_exp();
    repeat (2) begin
      @(negedge clk);
      exp_ren  = 1'b1;
      exp_addr = 32'h0000_0020;
    end
    #2;
    rst = 1'b1;
    #1;
    check("t4_ren", bus.ren, 32'd0);
    check("t4_wen", bus.wen, 32'd0);
    check("t4_ready", bus.mem_ready, 32'd0);
    check("t4_rdata", bus.mem_rdata, 32'd0);
    check("t4_state", dut.state_reg, IDLE);
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_valid = 1'b0;
    exp_rdata     = 32'd0;
    set_idle_exp();
    xfer(32'h4000_0020, 32'hCAFE_F00D, 4'hF, 1, c0);
    #2;
    check("t4_after_wr_cyc", last_rdy_cyc - c0, 32'd3);
    xfer(32'h4000_0020, 32'h0, 4'h0, 0, c0);
    #2;
    check("t4_after_rd_cyc", last_rdy_cyc - c0, 32'd2);
    check("t4_after_rdata", last_rdata, 32'hCAFE_F00D);

`ifdef LB_BRIDGE_TIMEOUT_EN
    // write that never gets wready
    w0 = wen_cnt;
    xfer(32'h4000_0030, 32'h0000_00AA, 4'hF, 100, c0);
    #2;
    check("t5_wen_cycles", wen_cnt - w0, 32'd8);
    check("t5_ready_cyc", last_rdy_cyc - c0, 32'd9);
    check("t5_lb_err", last_err, 32'd1);
    // read that never gets rvalid
    r0 = ren_cnt;
    xfer(32'h4000_0030, 32'h0, 4'h0, 100, c0);
    #2;
    check("t5_rd_ren_cycles", ren_cnt - r0, 32'd8);
    check("t5_rd_rdata", last_rdata, 32'hDEAD_BEEF);
    check("t5_rd_lb_err", last_err, 32'd1);
    // handshake in the expiry cycle completes normally
    xfer(32'h4000_0010, 32'h0, 4'h0, TO - 1, c0);
    #2;
    check("t5_edge_ready_cyc", last_rdy_cyc - c0, 32'd9);
    check("t5_edge_lb_err", last_err, 32'd0);
    check("t5_edge_rdata", last_rdata, 32'h0000_0001);
`endif

    // back-to-back write then read, random wait cycles
    k0 = rdy_cnt;
    for (int it = 0; it < 1000; it++) begin
      off = 32'($urandom_range(63, 0)) << 2;
      wd  = $urandom;
      ws  = 4'($urandom_range(15, 1));
      d   = $urandom_range(5, 0);
      xfer(32'h4000_0000 | off, wd, ws, d, c0);
      d   = $urandom_range(5, 0);
      off = 32'($urandom_range(63, 0)) << 2;
      xfer(32'h4000_0000 | off, 32'h0, 4'h0, d, c0);
    end
    idle(2, 1'b0);
    check("t6_ready_count", rdy_cnt - k0, 32'd2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lb_bridge

// File: doc/lb_bridge.md
# lb_bridge

Bridges the krv32 core's native memory interface (valid/ready, byte strobes) to the Corsair local bus used by the PWM IP and other CSR-based peripherals. It decodes one address window, converts each CPU access into exactly one local-bus write or read, and returns the read data and completion to the core. It sits between the core's data-memory port and a peripheral's local-bus ports (waddr/wdata/wen/wstrb/wready, raddr/ren/rdata/rvalid).

## Interface
- ADDR_W, 32, address width, both sides
- DATA_W, 32, data width, both sides
- STRB_W, DATA_W/8, byte-strobe width
- BASE_ADDR, 32'h4000_0000, window base; low bits under ADDR_MASK must be 0
- ADDR_MASK, 32'h0000_00FF, bits passed through as the local offset
- TIMEOUT_CYCLES, 64, local-bus wait limit; used only with LB_BRIDGE_TIMEOUT_EN
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  CPU request
- mem_addr  in  ADDR_W  CPU byte address
- mem_wdata  in  DATA_W  CPU write data
- mem_wstrb  in  STRB_W  nonzero = write, zero = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_W  read data, valid while mem_ready=1
- waddr, wdata, wstrb  out  ADDR_W/DATA_W/STRB_W  local-bus write channel
- wen  out  1  write request
- wready  in  1  write accepted
- raddr  out  ADDR_W  local-bus read address
- ren  out  1  read request
- rdata  in  DATA_W  local-bus read data
- rvalid  in  1  read data valid
- lb_err  out  1  one-cycle timeout pulse, coincident with mem_ready

## Operation
- hit = mem_valid && ((mem_addr & ~ADDR_MASK) == BASE_ADDR). A miss is ignored: no local-bus activity and mem_ready stays 0.
- Local offset = mem_addr & ADDR_MASK. It is registered into waddr or raddr; the other channel's address holds its last value.
- FSM states: IDLE, WR, RD, ACK.
  - IDLE: on hit with wstrb≠0, capture waddr/wdata/wstrb and go to WR. On hit with wstrb=0, capture raddr and go to RD.
  - WR: wen=1. When wready=1, go to ACK.
  - RD: ren=1. When rvalid=1, capture rdata into mem_rdata and go to ACK.
  - ACK: mem_ready=1 for exactly one cycle, then IDLE.
- wen and ren are never high together and never high outside WR/RD.
- The request must be held on the CPU side until mem_ready. The bridge ignores mem_* changes outside IDLE.
- mem_rdata is 0 on write completions and holds its value outside ACK.
- Reset (at any time, including mid-transaction) forces the state to IDLE and every output to 0. An aborted transfer is not completed.

## Timing
- All outputs are registered.
- Minimum latency: the request is sampled at edge 0, wen/ren is high in cycle 1, and wready/rvalid in cycle 1 gives mem_ready in cycle 2. Each wait cycle on wready/rvalid adds one cycle.
- Back-to-back: a new hit is accepted at the first IDLE cycle after ACK, so the earliest request sampling is cycle 3.
- wready or rvalid arriving while not in WR/RD is ignored.

## Configuration
- LB_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on entering WR/RD and increments each wait cycle.
  - When it reaches TIMEOUT_CYCLES-1 without wready/rvalid, wen/ren drops and the FSM goes to ACK.
  - On a timed-out read, mem_rdata = 32'hDEAD_BEEF.
  - lb_err pulses together with mem_ready.
  - A handshake that arrives in the same cycle as expiry wins: normal completion, no error.
- LB_BRIDGE_TIMEOUT_EN undefined:
  - The bridge waits indefinitely.
  - lb_err is tied to 0 and no counter is synthesised.

## Structure
- lb_bridge_pkg contains the state encoding (IDLE=2'd0, WR=2'd1, RD=2'd2, ACK=2'd3) and the LB_ERR_DATA=32'hDEAD_BEEF constant.
- Optional sub-module lb_watchdog (counter plus expiry compare) is instantiated only under LB_BRIDGE_TIMEOUT_EN.

## Test plan
- Write 0x4000_0004, wdata 0x0000_0080, wstrb 4'hF, wready tied high:
  - Required: wen=1 in cycle 1 with waddr=0x04, wdata=0x80.
  - Required: mem_ready=1 in cycle 2, lb_err=0.
- Read 0x4000_0010 with rvalid delayed 3 cycles, rdata=0x0000_0001:
  - Required: ren high for cycles 1–4, then mem_ready with mem_rdata=0x1 in cycle 5.
- Access to 0x5000_0000:
  - Required: no wen/ren and no mem_ready within 20 cycles.
- rst asserted during RD with ren high:
  - Required: ren, mem_ready and mem_rdata are 0 in the same cycle; the FSM is in IDLE.
  - Required: the next hit completes normally.
- TIMEOUT_EN with TIMEOUT_CYCLES=8 and wready never asserted:
  - Required: wen high for 8 cycles, then mem_ready=1 and lb_err=1 together.
  - Repeat as a read: required mem_rdata=0xDEAD_BEEF.
- Write followed immediately by a read, with a random 0–5 cycle ready delay per transfer, 1000 iterations:
  - Required: wen and ren are never both high, exactly one mem_ready per request, and read data matches the scoreboard.
